// File: rtl/control_sequencer_if.sv
// Signal bundle between the microcode sequencer and the CPU datapath:
// step/opcode/flag inputs plus the per-step control word.
interface control_sequencer_if;
  logic       STEP_EN;
  logic [3:0] OPCODE;
  logic       FLAG_C;
  logic       FLAG_Z;
  logic [2:0] STEP;
  logic       HALTED;
  logic       CO, RO, IO, AO, EO, SU;
  logic       MI, RI, II, AI, BI, OI, FI;
  logic       CE;
  logic       Jn;

  modport master (
    output STEP_EN, OPCODE, FLAG_C, FLAG_Z,
    input  STEP, HALTED, CO, RO, IO, AO, EO, SU,
    input  MI, RI, II, AI, BI, OI, FI, CE, Jn
  );

  modport slave (
    input  STEP_EN, OPCODE, FLAG_C, FLAG_Z,
    output STEP, HALTED, CO, RO, IO, AO, EO, SU,
    output MI, RI, II, AI, BI, OI, FI, CE, Jn
  );
endinterface

// File: rtl/control_sequencer.sv
// Microcode sequencer: T-state counter, halt latch and the combinational
// per-step control word decoded from the IR opcode nibble and ALU flags.
module control_sequencer (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                CLR,
  control_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} step_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7,
    OP_JZ  = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF
  } opcode_t;

  step_t      step;
  logic       halted;
  logic [2:0] last_step;
  logic       co, ro, io, ao, eo, su;
  logic       mi, ri, ii, ai, bi, oi, fi, ce, j;

  always_comb begin
    case (bus.OPCODE)
      OP_LDA, OP_STA:                                    last_step = 3'd3;
      OP_ADD, OP_SUB:                                    last_step = 3'd4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:      last_step = 3'd2;
      default:                                           last_step = 3'd1;
    endcase
  end

  always_comb begin
    co = 1'b0; ro = 1'b0; io = 1'b0; ao = 1'b0; eo = 1'b0; su = 1'b0;
    mi = 1'b0; ri = 1'b0; ii = 1'b0; ai = 1'b0; bi = 1'b0; oi = 1'b0;
    fi = 1'b0; ce = 1'b0; j  = 1'b0;
    if (!halted) begin
      case (step)
        T0: begin co = 1'b1; mi = 1'b1; end
        T1: begin ro = 1'b1; ii = 1'b1; ce = 1'b1; end
        T2: begin
          case (bus.OPCODE)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin io = 1'b1; mi = 1'b1; end
            OP_LDI: begin io = 1'b1; ai = 1'b1; end
            OP_JMP: begin io = 1'b1; j = 1'b1; end
            OP_JC:  begin io = 1'b1; j = bus.FLAG_C; end
            OP_JZ:  begin io = 1'b1; j = bus.FLAG_Z; end
            OP_OUT: begin ao = 1'b1; oi = 1'b1; end
            default: ;
          endcase
        end
        T3: begin
          case (bus.OPCODE)
            OP_LDA:         begin ro = 1'b1; ai = 1'b1; end
            OP_ADD, OP_SUB: begin ro = 1'b1; bi = 1'b1; end
            OP_STA:         begin ao = 1'b1; ri = 1'b1; end
            default: ;
          endcase
        end
        T4: begin
          case (bus.OPCODE)
            OP_ADD: begin eo = 1'b1; ai = 1'b1; fi = 1'b1; end
            OP_SUB: begin eo = 1'b1; ai = 1'b1; fi = 1'b1; su = 1'b1; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Drive strobes pass straight through; loads and PC control only fire on enabled steps.
  assign bus.CO = co;
  assign bus.RO = ro;
  assign bus.IO = io;
  assign bus.AO = ao;
  assign bus.EO = eo;
  assign bus.SU = su;
  assign bus.MI = mi & bus.STEP_EN;
  assign bus.RI = ri & bus.STEP_EN;
  assign bus.II = ii & bus.STEP_EN;
  assign bus.AI = ai & bus.STEP_EN;
  assign bus.BI = bi & bus.STEP_EN;
  assign bus.OI = oi & bus.STEP_EN;
  assign bus.FI = fi & bus.STEP_EN;
  assign bus.CE = ce & bus.STEP_EN;
  assign bus.Jn = ~(j & bus.STEP_EN);

  assign bus.STEP   = step;
  assign bus.HALTED = halted;

  // ">=" rather than "==" keeps STEP bounded if the opcode shortens mid-instruction.
  always_ff @(posedge CLK) begin
    if (!RESETn || CLR) begin
      step   <= T0;
      halted <= 1'b0;
    end else if (bus.STEP_EN && !halted) begin
      if (bus.OPCODE == OP_HLT && step == T2) begin
        halted <= 1'b1;
        step   <= T0;
      end else if (step >= last_step) begin
        step <= T0;
      end else begin
        step <= step_t'(step + 3'd1);
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a table-driven microcode model
// predicts each cycle's outputs; a monitor compares at the falling edge.
module tb_control_sequencer;

  logic CLK = 1'b0;
  logic RESETn;
  logic CLR;

  control_sequencer_if bus ();

  control_sequencer dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .CLR    (CLR),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  // Control bit positions: {CO,RO,IO,AO,EO,SU,MI,RI,II,AI,BI,OI,FI,CE,J}
  localparam logic [14:0] B_CO = 15'h4000, B_RO = 15'h2000, B_IO = 15'h1000;
  localparam logic [14:0] B_AO = 15'h0800, B_EO = 15'h0400, B_SU = 15'h0200;
  localparam logic [14:0] B_MI = 15'h0100, B_RI = 15'h0080, B_II = 15'h0040;
  localparam logic [14:0] B_AI = 15'h0020, B_BI = 15'h0010, B_OI = 15'h0008;
  localparam logic [14:0] B_FI = 15'h0004, B_CE = 15'h0002, B_J  = 15'h0001;
  localparam logic [14:0] LOADS = B_MI | B_RI | B_II | B_AI | B_BI | B_OI | B_FI | B_CE | B_J;

  logic [14:0] ucode [16][5];
  int          ilen  [16];

  int m_step, m_halted;
  int cur_op, cur_en, cur_fc, cur_fz, cur_clr, cur_rstn;

  logic [18:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;
  int cycle_no = 0;
  string phase = "reset";

  initial begin
    for (int op = 0; op < 16; op++) begin
      ilen[op] = 2;
      for (int s = 0; s < 5; s++) ucode[op][s] = '0;
      ucode[op][0] = B_CO | B_MI;
      ucode[op][1] = B_RO | B_II | B_CE;
    end
    ilen[1] = 4; ucode[1][2] = B_IO | B_MI; ucode[1][3] = B_RO | B_AI;
    ilen[2] = 5; ucode[2][2] = B_IO | B_MI; ucode[2][3] = B_RO | B_BI;
    ucode[2][4] = B_EO | B_AI | B_FI;
    ilen[3] = 5; ucode[3][2] = B_IO | B_MI; ucode[3][3] = B_RO | B_BI;
    ucode[3][4] = B_EO | B_AI | B_FI | B_SU;
    ilen[4] = 4; ucode[4][2] = B_IO | B_MI; ucode[4][3] = B_AO | B_RI;
    ilen[5] = 3; ucode[5][2] = B_IO | B_AI;
    ilen[6] = 3; ucode[6][2] = B_IO | B_J;
    ilen[7] = 3; ucode[7][2] = B_IO | B_J;
    ilen[8] = 3; ucode[8][2] = B_IO | B_J;
    ilen[14] = 3; ucode[14][2] = B_AO | B_OI;
    ilen[15] = 3;
  end

  function automatic logic [18:0] expected();
    logic [14:0] c;
    if (m_halted != 0) c = '0;
    else c = ucode[cur_op][m_step];
    if (m_step == 2 && cur_op == 7 && cur_fc == 0) c &= ~B_J;
    if (m_step == 2 && cur_op == 8 && cur_fz == 0) c &= ~B_J;
    if (cur_en == 0) c &= ~LOADS;
    return {m_step[2:0], (m_halted != 0), c[14:1], ~c[0]};
  endfunction

  task automatic cyc(input int op, input int en, input int fc, input int fz,
                     input int clr, input int rstn);
    @(posedge CLK);
    #1;
    if (cur_rstn == 0 || cur_clr == 1) begin
      m_step = 0; m_halted = 0;
    end else if (cur_en == 1 && m_halted == 0) begin
      if (cur_op == 15 && m_step == 2) begin
        m_halted = 1; m_step = 0;
      end else if (m_step >= ilen[cur_op] - 1) m_step = 0;
      else m_step = m_step + 1;
    end
    cur_op = op; cur_en = en; cur_fc = fc; cur_fz = fz; cur_clr = clr; cur_rstn = rstn;
    bus.OPCODE = op[3:0]; bus.STEP_EN = en[0]; bus.FLAG_C = fc[0]; bus.FLAG_Z = fz[0];
    CLR = clr[0]; RESETn = rstn[0];
    cycle_no++;
    exp_q.push_back(expected());
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      logic [18:0] e, g;
      e = exp_q.pop_front();
      g = {bus.STEP, bus.HALTED, bus.CO, bus.RO, bus.IO, bus.AO, bus.EO, bus.SU,
           bus.MI, bus.RI, bus.II, bus.AI, bus.BI, bus.OI, bus.FI, bus.CE, bus.Jn};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got step=%0d halt=%b ctl=%h, expected step=%0d halt=%b ctl=%h",
                 phase, cycle_no, g[18:16], g[15], g[14:0], e[18:16], e[15], e[14:0]);
      end
    end
  end

  initial begin
    int op, en, fc, fz, clr, rstn;
    RESETn = 1'b0; CLR = 1'b0;
    bus.STEP_EN = 1'b1; bus.OPCODE = 4'h1; bus.FLAG_C = 1'b0; bus.FLAG_Z = 1'b0;
    cur_op = 1; cur_en = 1; cur_fc = 0; cur_fz = 0; cur_clr = 0; cur_rstn = 0;
    m_step = 0; m_halted = 0;

    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    phase = "lda";
    repeat (5) cyc(1, 1, 0, 0, 0, 1);
    phase = "sub";
    repeat (6) cyc(3, 1, 0, 0, 0, 1);
    phase = "jc";
    repeat (3) cyc(7, 1, 0, 1, 0, 1);
    repeat (3) cyc(7, 1, 1, 0, 0, 1);
    phase = "jz";
    repeat (3) cyc(8, 1, 1, 0, 0, 1);
    repeat (3) cyc(8, 1, 0, 1, 0, 1);
    phase = "hlt";
    repeat (15) cyc(15, 1, 1, 1, 0, 1);
    phase = "clr";
    cyc(0, 1, 0, 0, 1, 1);
    repeat (3) cyc(0, 1, 0, 0, 0, 1);
    phase = "add_stall";
    cyc(2, 1, 0, 0, 0, 1);
    cyc(2, 1, 0, 0, 0, 1);
    cyc(2, 0, 0, 0, 0, 1);
    cyc(2, 0, 0, 0, 0, 1);
    repeat (5) cyc(2, 1, 0, 0, 0, 1);
    phase = "add_reset";
    repeat (3) cyc(2, 1, 0, 0, 0, 1);
    cyc(2, 1, 0, 0, 0, 0);
    repeat (2) cyc(2, 1, 0, 0, 0, 1);
    phase = "undef";
    repeat (5) cyc(10, 1, 0, 0, 0, 1);

    phase = "random";
    op = 0;
    for (int i = 0; i < 600; i++) begin
      if (m_step <= 1 && $urandom_range(0, 2) == 0) begin
        op = $urandom_range(0, 15);
        if (op == 15 && $urandom_range(0, 3) != 0) op = 0;
      end
      en   = ($urandom_range(0, 4) != 0) ? 1 : 0;
      fc   = $urandom_range(0, 1);
      fz   = $urandom_range(0, 1);
      clr  = ($urandom_range(0, 99) < 3) ? 1 : 0;
      rstn = ($urandom_range(0, 99) < 2) ? 0 : 1;
      cyc(op, en, fc, fz, clr, rstn);
    end

    @(negedge CLK);
    @(negedge CLK);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
